// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, the bubble instruction word
// and the fetch-queue entry layout.
package cpu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned PC_BITS = 5;

   // All-zero word shown to decode while the fetch queue is empty
   localparam logic [XLEN-1:0] NOP_INST = '0;

   typedef struct packed {
      logic [PC_BITS-1:0] pc;
      logic [XLEN-1:0]    inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; owns pointers and occupancy.
// clear has priority over push and pop; count saturates at DEPTH.
module fetch_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (!clear && do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The fetch credit scheme must never deliver a push into a full queue
   a_no_overflow: assert property (@(posedge clk) disable iff (clear) !(push && full))
      else $error("fetch_fifo overflow");

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front-end: owns the fetch PC and in-flight credit, issues imem reads and
// buffers returned {pc, inst} pairs so fetch can run ahead of a stalled decode.
module fetch_queue_unit #(
   parameter int unsigned         XLEN     = cpu_pkg::XLEN,
   parameter int unsigned         PC_BITS  = cpu_pkg::PC_BITS,
   parameter int unsigned         FQ_DEPTH = 4,
   parameter logic [PC_BITS-1:0]  RESET_PC = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          redirect_valid,
   input  logic [PC_BITS-1:0]            redirect_pc,
   output logic                          imem_req,
   output logic [PC_BITS-1:0]            imem_addr,
   input  logic [XLEN-1:0]               imem_rdata,
   input  logic                          D_ready,
   output logic                          D_valid,
   output logic [PC_BITS-1:0]            D_pc,
   output logic [XLEN-1:0]               D_inst,
   output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

   import cpu_pkg::*;

   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

   typedef struct packed {
      logic [PC_BITS-1:0] pc;
      logic [XLEN-1:0]    inst;
   } entry_t;

   logic [PC_BITS-1:0] F_pc;
   logic [PC_BITS-1:0] inflight_pc;
   logic               inflight;
   logic [CW:0]        occupancy;
   logic               fq_clear;
   logic               fq_push;
   logic               fq_pop;
   logic               fq_empty;
   entry_t             push_entry;
   entry_t             head_entry;

   // Credit counts the queued entries plus the one response still in the memory pipe
   assign occupancy = {1'b0, fq_count} + (CW+1)'(inflight);
   assign imem_req  = !rst && !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
   assign imem_addr = F_pc;

   assign fq_clear   = rst || redirect_valid;
   assign fq_push    = inflight;
   assign fq_pop     = D_valid && D_ready;
   assign push_entry = '{pc: inflight_pc, inst: imem_rdata};

   always_ff @(posedge clk) begin
      if (rst) begin
         F_pc        <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         F_pc     <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            F_pc        <= F_pc + PC_BITS'(1);
            inflight_pc <= F_pc;
         end
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_fifo (
      .clk   (clk),
      .clear (fq_clear),
      .push  (fq_push),
      .wdata (push_entry),
      .pop   (fq_pop),
      .rdata (head_entry),
      .empty (fq_empty),
      .count (fq_count)
   );

   assign D_valid = !fq_empty;
   assign D_pc    = D_valid ? head_entry.pc   : '0;
   assign D_inst  = D_valid ? head_entry.inst : XLEN'(NOP_INST);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus randomized
// stall/redirect/reset traffic checked against an in-order PC stream model.
module tb_fetch_queue_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned PC_BITS  = 5;
   localparam int unsigned FQ_DEPTH = 4;
   localparam int unsigned CW       = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               redirect_valid = 1'b0;
   logic [PC_BITS-1:0] redirect_pc = '0;
   logic               D_ready = 1'b1;

   logic               imem_req;
   logic [PC_BITS-1:0] imem_addr;
   logic [XLEN-1:0]    imem_rdata;
   logic               D_valid;
   logic [PC_BITS-1:0] D_pc;
   logic [XLEN-1:0]    D_inst;
   logic [CW-1:0]      fq_count;

   logic               w_imem_req;
   logic [PC_BITS-1:0] w_imem_addr;
   logic [XLEN-1:0]    w_imem_rdata;
   logic               w_D_valid;
   logic [PC_BITS-1:0] w_D_pc;
   logic [XLEN-1:0]    w_D_inst;
   logic [CW-1:0]      w_fq_count;

   fetch_queue_unit #(
      .XLEN     (XLEN),
      .PC_BITS  (PC_BITS),
      .FQ_DEPTH (FQ_DEPTH),
      .RESET_PC (5'h00)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .D_ready        (D_ready),
      .D_valid        (D_valid),
      .D_pc           (D_pc),
      .D_inst         (D_inst),
      .fq_count       (fq_count)
   );

   // Second instance exercises PC wrap from a non-zero reset PC
   fetch_queue_unit #(
      .XLEN     (XLEN),
      .PC_BITS  (PC_BITS),
      .FQ_DEPTH (FQ_DEPTH),
      .RESET_PC (5'h1E)
   ) dut_w (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (1'b0),
      .redirect_pc    (5'h00),
      .imem_req       (w_imem_req),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .D_ready        (1'b1),
      .D_valid        (w_D_valid),
      .D_pc           (w_D_pc),
      .D_inst         (w_D_inst),
      .fq_count       (w_fq_count)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] mem_word(input logic [PC_BITS-1:0] a);
      return 32'h100 + 32'(a);
   endfunction

   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= mem_word(imem_addr);
      if (w_imem_req) w_imem_rdata <= mem_word(w_imem_addr);
   end

   int n_checks = 0;
   int n_pass   = 0;
   int accepts  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic at_sample();
      @(negedge clk);
   endtask

   // Reference model: after reset/redirect, decode must see pc, pc+1, ... in order
   logic [PC_BITS-1:0] model_pc = '0;
   logic [PC_BITS-1:0] exp_q [$];

   always @(negedge clk) begin
      logic [PC_BITS-1:0] e;
      if (rst) begin
         exp_q.delete();
         model_pc = 5'h00;
      end else if (redirect_valid) begin
         exp_q.delete();
         model_pc = redirect_pc;
      end else if (D_valid && D_ready) begin
         if (exp_q.size() == 0) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 5'd1;
         end
         e = exp_q.pop_front();
         check("sb_pc", 64'(D_pc), 64'(e));
         check("sb_inst", 64'(D_inst), 64'(mem_word(e)));
         accepts++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PC_BITS-1:0] ew;

      rst = 1'b1; D_ready = 1'b1; redirect_valid = 1'b0;
      repeat (3) next_cycle();
      at_sample();
      check("rst_req", 64'(imem_req), 64'(0));
      check("rst_valid", 64'(D_valid), 64'(0));
      check("rst_pc", 64'(D_pc), 64'(0));
      check("rst_inst", 64'(D_inst), 64'(0));
      check("rst_count", 64'(fq_count), 64'(0));
      check("rst_w_valid", 64'(w_D_valid), 64'(0));
      next_cycle();

      // Streaming from reset, plus wrap on the RESET_PC=0x1E instance
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         at_sample();
         if (c == 0) check("t1_req_c0", 64'(imem_req), 64'(1));
         if (c < 2) begin
            check("t1_valid_early", 64'(D_valid), 64'(0));
            check("t4_valid_early", 64'(w_D_valid), 64'(0));
         end else begin
            check("t1_valid", 64'(D_valid), 64'(1));
            check("t1_pc", 64'(D_pc), 64'(c - 2));
            check("t1_inst", 64'(D_inst), 64'(32'h100 + c - 2));
            ew = 5'(30 + c - 2);
            check("t4_valid", 64'(w_D_valid), 64'(1));
            check("t4_pc", 64'(w_D_pc), 64'(ew));
            check("t4_inst", 64'(w_D_inst), 64'(mem_word(ew)));
         end
         next_cycle();
      end

      // Stall from reset until full, then drain in order
      rst = 1'b1; D_ready = 1'b0;
      at_sample();
      check("t2_req_in_rst", 64'(imem_req), 64'(0));
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         at_sample();
         if (c >= 2) begin
            check("t2_head_valid", 64'(D_valid), 64'(1));
            check("t2_head_stable", 64'(D_pc), 64'(0));
         end
         if (c >= 5) begin
            check("t2_full_count", 64'(fq_count), 64'(FQ_DEPTH));
            check("t2_req_full", 64'(imem_req), 64'(0));
         end
         next_cycle();
      end
      D_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         at_sample();
         check("t2_drain_valid", 64'(D_valid), 64'(1));
         check("t2_drain_pc", 64'(D_pc), 64'(i));
         next_cycle();
      end

      // Redirect with three queued entries and a request in flight
      rst = 1'b1; D_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
      repeat (4) begin
         at_sample();
         next_cycle();
      end
      redirect_valid = 1'b1; redirect_pc = 5'h1A;
      at_sample();
      check("t3_count_before", 64'(fq_count), 64'(3));
      check("t3_req_redirect", 64'(imem_req), 64'(0));
      next_cycle();
      redirect_valid = 1'b0;
      at_sample();
      check("t3_count_flushed", 64'(fq_count), 64'(0));
      check("t3_valid_t1", 64'(D_valid), 64'(0));
      check("t3_req_t1", 64'(imem_req), 64'(1));
      check("t3_addr_t1", 64'(imem_addr), 64'(5'h1A));
      next_cycle();
      at_sample();
      check("t3_valid_t2", 64'(D_valid), 64'(0));
      next_cycle();
      D_ready = 1'b1;
      at_sample();
      check("t3_valid_t3", 64'(D_valid), 64'(1));
      check("t3_pc_t3", 64'(D_pc), 64'(5'h1A));
      next_cycle();
      at_sample();
      check("t3_pc_t4", 64'(D_pc), 64'(5'h1B));
      next_cycle();

      // Redirect coinciding with a pop and a push
      repeat (3) begin
         at_sample();
         next_cycle();
      end
      redirect_valid = 1'b1; redirect_pc = 5'h05;
      at_sample();
      check("t5_pop_offered", 64'(D_valid && D_ready), 64'(1));
      next_cycle();
      redirect_valid = 1'b0;
      at_sample();
      check("t5_count_flushed", 64'(fq_count), 64'(0));
      check("t5_valid_t1", 64'(D_valid), 64'(0));
      next_cycle();
      at_sample();
      check("t5_valid_t2", 64'(D_valid), 64'(0));
      next_cycle();
      at_sample();
      check("t5_valid_t3", 64'(D_valid), 64'(1));
      check("t5_pc_t3", 64'(D_pc), 64'(5'h05));
      next_cycle();

      // One-cycle reset with the queue full and decode ready
      D_ready = 1'b0;
      repeat (8) begin
         at_sample();
         next_cycle();
      end
      at_sample();
      check("t6_full", 64'(fq_count), 64'(FQ_DEPTH));
      next_cycle();
      rst = 1'b1; D_ready = 1'b1;
      at_sample();
      check("t6_req_in_rst", 64'(imem_req), 64'(0));
      next_cycle();
      rst = 1'b0;
      at_sample();
      check("t6_valid", 64'(D_valid), 64'(0));
      check("t6_pc", 64'(D_pc), 64'(0));
      check("t6_inst", 64'(D_inst), 64'(0));
      check("t6_count", 64'(fq_count), 64'(0));
      check("t6_addr", 64'(imem_addr), 64'(0));
      next_cycle();
      at_sample();
      check("t6_valid_c1", 64'(D_valid), 64'(0));
      next_cycle();
      at_sample();
      check("t6_valid_c2", 64'(D_valid), 64'(1));
      check("t6_pc_c2", 64'(D_pc), 64'(0));
      next_cycle();

      // Randomized decode stalls, redirects and occasional resets
      for (int n = 0; n < 500; n++) begin
         D_ready        = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 5'($urandom_range(0, 31));
         rst            = ($urandom_range(0, 149) == 0);
         at_sample();
         check("rnd_count_bound", 64'(fq_count <= CW'(FQ_DEPTH)), 64'(1));
         check("rnd_valid_vs_count", 64'(D_valid), 64'(fq_count != '0));
         next_cycle();
      end
      rst = 1'b0; redirect_valid = 1'b0; D_ready = 1'b1;
      at_sample();
      check("accepts_seen", 64'(accepts >= 50), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
